seq_divider: RTL and testbench



---
 rtl/mdu_pkg.sv | 23 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide units.
// Holds the funct3 opcode encodings, the divider state type and the special-case result constants.
package mdu_pkg;

  localparam int unsigned MDU_XLEN  = 32;
  localparam int unsigned MDU_CNT_W = 6;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_FIN  = 2'd3
  } div_state_e;

  localparam logic [MDU_XLEN-1:0] DIV0_QUOT = {MDU_XLEN{1'b1}};
  localparam logic [MDU_XLEN-1:0] INT_MIN   = {1'b1, {(MDU_XLEN-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// The partial remainder is widened by one bit so the shifted value never loses its MSB.
module div_step
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dvd_msb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_next_rem_c,
  output logic            o_q_bit_c
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {i_rem, i_dvd_msb};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // No borrow out of the subtract means the shifted remainder covers the divisor.
  assign o_q_bit_c    = ~w_diff[XLEN];
  assign o_next_rem_c = o_q_bit_c ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module seq_divider
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN  = MDU_XLEN,
  parameter int unsigned CNT_W = MDU_CNT_W
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [1:0]      SELECT,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  localparam logic [XLEN-1:0] L_INT_MIN = XLEN'(INT_MIN);
  localparam logic [XLEN-1:0] L_ALL_ONE = XLEN'(DIV0_QUOT);

  div_state_e r_state;
  div_state_e w_next;

  logic [1:0]      r_op;
  logic            r_q_neg;
  logic            r_r_neg;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quot;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_result;
  logic            r_busy;
  logic            r_done;

  logic            w_signed;
  logic            w_is_rem;
  logic            w_div0;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN-1:0] w_fix_res;
  logic [XLEN-1:0] w_step_rem;
  logic            w_q_bit;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  // Decode of the raw request operands, only meaningful in IDLE.
  assign w_signed   = ~SELECT[0];
  assign w_is_rem   = SELECT[1];
  assign w_div0     = (DATA2 == '0);
  assign w_ovf      = w_signed && (DATA1 == L_INT_MIN) && (DATA2 == L_ALL_ONE);
  assign w_fast     = w_div0 | w_ovf;
  assign w_fast_res = w_div0 ? (w_is_rem ? DATA1 : L_ALL_ONE)
                             : (w_is_rem ? '0 : L_INT_MIN);
  assign w_abs1     = (w_signed && DATA1[XLEN-1]) ? (~DATA1 + XLEN'(1)) : DATA1;
  assign w_abs2     = (w_signed && DATA2[XLEN-1]) ? (~DATA2 + XLEN'(1)) : DATA2;

  assign w_fix_res = r_op[1] ? (r_r_neg ? (~r_rem  + XLEN'(1)) : r_rem)
                             : (r_q_neg ? (~r_quot + XLEN'(1)) : r_quot);

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem        (r_rem),
    .i_dvd_msb    (r_dvd[XLEN-1]),
    .i_divisor    (r_dvs),
    .o_next_rem_c (w_step_rem),
    .o_q_bit_c    (w_q_bit)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: if (START) w_next = w_fast ? S_FIN : S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_busy_nxt = (w_next == S_CALC) || (w_next == S_FIX);
    w_done_nxt = (w_next == S_FIN);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_op     <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_op    <= SELECT;
            r_q_neg <= w_signed & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
            r_r_neg <= w_signed & DATA1[XLEN-1];
            r_dvd   <= w_abs1;
            r_dvs   <= w_abs2;
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= CNT_W'(XLEN - 1);
            if (w_fast) r_result <= w_fast_res;
          end
        end
        S_CALC: begin
          r_rem  <= w_step_rem;
          r_quot <= {r_quot[XLEN-2:0], w_q_bit};
          r_dvd  <= {r_dvd[XLEN-2:0], 1'b0};
          r_cnt  <= r_cnt - CNT_W'(1);
        end
        S_FIX:   r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign RESULT = r_result;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
// A forked monitor tracks acceptance itself and checks RESULT/BUSY/DONE every cycle.
module tb_seq_divider;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [1:0]  SELECT;
  logic [31:0] RESULT;
  logic        BUSY;
  logic        DONE;

  int n_tests;
  int n_fail;

  seq_divider dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .SELECT (SELECT),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // RISC-V M semantics written directly with SV arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Monitor: decides acceptance from the protocol rules and checks outputs at every negedge.
  task automatic monitor();
    logic        act;
    int          cyc;
    int          lat;
    logic [31:0] exp_res;
    logic [31:0] hold;
    act = 1'b0; cyc = 0; lat = 0; exp_res = '0; hold = '0;
    forever begin
      @(posedge CLK);
      if (RESET) act = 1'b0;
      else if (act && cyc == lat) act = 1'b0;
      else if (!act && START) begin
        act     = 1'b1;
        cyc     = 0;
        lat     = lat_of(SELECT, DATA1, DATA2);
        exp_res = model(SELECT, DATA1, DATA2);
      end
      @(negedge CLK);
      if (RESET) begin
        act  = 1'b0;
        hold = '0;
        chk("mon_rst_result", RESULT, 32'd0);
        chk("mon_rst_busy", 32'(BUSY), 32'd0);
        chk("mon_rst_done", 32'(DONE), 32'd0);
      end else if (act) begin
        cyc++;
        if (cyc == lat) hold = exp_res;
        chk("mon_done", 32'(DONE), 32'(cyc == lat));
        chk("mon_busy", 32'(BUSY), 32'(lat != 1 && cyc < lat));
        chk("mon_result", RESULT, hold);
      end else begin
        chk("mon_idle_done", 32'(DONE), 32'd0);
        chk("mon_idle_busy", 32'(BUSY), 32'd0);
        chk("mon_idle_result", RESULT, hold);
      end
    end
  endtask

  // Issue one operation; returns edges to DONE and number of BUSY cycles seen.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output int busy_cnt);
    @(negedge CLK);
    DATA1 = a; DATA2 = b; SELECT = op; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    DATA1 = $urandom; DATA2 = $urandom; SELECT = 2'($urandom_range(0, 3));
    n = 1;
    busy_cnt = int'(BUSY);
    while (!DONE && n < 60) begin
      @(negedge CLK);
      n++;
      busy_cnt += int'(BUSY);
    end
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int n;
    int bc;
    issue(op, a, b, n, bc);
    chk({name, "_lat"}, 32'(n), 32'(exp_lat));
    chk({name, "_res"}, RESULT, exp_r);
  endtask

  initial begin
    int n;
    int bc;
    int dones;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    n_tests = 0; n_fail = 0;
    RESET = 1'b1; START = 1'b0; DATA1 = '0; DATA2 = '0; SELECT = '0;
    fork monitor(); join_none

    // Hand-computed values pinning the reference model.
    chk("model_div", model(2'b00, 32'd7, 32'hFFFF_FFFE), 32'hFFFF_FFFD);
    chk("model_rem", model(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_remu", model(2'b11, 32'hFFFF_FFF9, 32'd2), 32'h0000_0001);
    chk("model_ovf_lat", 32'(lat_of(2'b00, 32'h8000_0000, 32'hFFFF_FFFF)), 32'd1);

    repeat (3) @(negedge CLK);
    chk("reset_result", RESULT, 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    issue(2'b00, 32'd7, 32'hFFFF_FFFE, n, bc);
    chk("div7_lat", 32'(n), 32'd34);
    chk("div7_busy_cycles", 32'(bc), 32'd33);
    chk("div7_res", RESULT, 32'hFFFF_FFFD);
    directed("rem_neg7", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    directed("remu", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34);
    directed("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    directed("div_by0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    directed("remu_by0", 2'b11, 32'd5, 32'd0, 32'h0000_0005, 1);
    directed("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    directed("divu_ovf_ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);

    // Second START at E10 with different operands must be ignored.
    @(negedge CLK);
    DATA1 = 32'd100; DATA2 = 32'd7; SELECT = 2'b01; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    DATA1 = 32'd9; DATA2 = 32'd3; SELECT = 2'b00; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 11;
    while (!DONE && n < 60) begin @(negedge CLK); n++; end
    chk("restart_lat", 32'(n), 32'd34);
    chk("restart_res", RESULT, 32'd14);

    // START held through the DONE cycle: ignored in FIN, accepted the cycle after.
    DATA1 = 32'hFFFF_FF9C; DATA2 = 32'd7; SELECT = 2'b00; START = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b0;
    n = 1;
    while (!DONE && n < 60) begin @(negedge CLK); n++; end
    chk("b2b_lat", 32'(n), 32'd34);
    chk("b2b_res", RESULT, 32'hFFFF_FFF2);

    // Asynchronous reset mid-operation at E15.
    @(negedge CLK);
    DATA1 = 32'd1000; DATA2 = 32'd3; SELECT = 2'b01; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (14) @(negedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_busy", 32'(BUSY), 32'd0);
    chk("async_rst_done", 32'(DONE), 32'd0);
    chk("async_rst_result", RESULT, 32'd0);
    @(negedge CLK);
    #2 RESET = 1'b0;
    dones = 0;
    repeat (40) begin @(negedge CLK); dones += int'(DONE); end
    chk("no_done_after_rst", 32'(dones), 32'd0);

    // Randomized operations; the monitor checks every cycle.
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(1, 9)) - 32'd5; end
        3:       begin a = $urandom; b = 32'($urandom_range(1, 300)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      issue(op, a, b, n, bc);
      chk("rand_lat", 32'(n), 32'(lat_of(op, a, b)));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
